// File: rtl/rv_pkg.sv
// Shared RV32I decode constants for the hazard controller and the
// branch-forwarding unit: opcode values, instruction field positions,
// the bubble word, and small field-extraction helpers.
package rv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] L_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam int RS1_HI = 19, RS1_LO = 15;
  localparam int RS2_HI = 24, RS2_LO = 20;
  localparam int RD_HI  = 11, RD_LO  = 7;
  localparam int OP_HI  = 6,  OP_LO  = 0;

  // Opcode 0 is read as "empty slot" downstream.
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  function automatic logic [4:0] f_rs1(input logic [31:0] inst);
    return inst[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] inst);
    return inst[RS2_HI:RS2_LO];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] inst);
    return inst[RD_HI:RD_LO];
  endfunction

  function automatic logic [6:0] f_op(input logic [31:0] inst);
    return inst[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/inst_src_decode.sv
// Combinational opcode classifier: which register sources an instruction
// reads and whether it writes rd (rd == x0 is filtered by the caller).
// Ports:
//   i_opcode    - instruction opcode [6:0]
//   o_uses_rs1  - instruction reads rs1
//   o_uses_rs2  - instruction reads rs2
//   o_writes_rd - instruction class writes rd
module inst_src_decode
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_writes_rd
);

  always_comb begin
    o_uses_rs1  = 1'b0;
    o_uses_rs2  = 1'b0;
    o_writes_rd = 1'b0;
    unique case (i_opcode)
      R_TYPE:                 begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; o_writes_rd = 1'b1; end
      B_TYPE, S_TYPE:         begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
      I_TYPE, L_TYPE, JALR:   begin o_uses_rs1 = 1'b1; o_writes_rd = 1'b1; end
      JAL, LUI, AUIPC:        o_writes_rd = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: holds the ID/EX/MEM/WB instruction words,
// detects hazards forwarding cannot cover (load-use, branch operand still
// coming from a load in MEM), stalls fetch/decode with bubbles, and flushes
// the wrong-path fetch on a taken branch.
// Ports:
//   clk, rst        - clock (rising), async active-high reset
//   if_inst         - instruction fetched this cycle
//   branch_taken    - branch/jump in ID resolved taken
//   ext_stall       - external freeze of the whole pipeline
//   inst_id..inst_wb- stage instruction words
//   pc_write_en     - PC may advance
//   hazard_stall    - hazard stall active this cycle
//   flush_if        - fetched instruction is discarded
//   stall_count     - saturating count of hazard-stall cycles
module pipe_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int          CNT_W  = 16,
  parameter logic [31:0] BUBBLE = rv_pkg::BUBBLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_inst,
  input  logic             branch_taken,
  input  logic             ext_stall,
  output logic [31:0]      inst_id,
  output logic [31:0]      inst_ex,
  output logic [31:0]      inst_mem,
  output logic [31:0]      inst_wb,
  output logic             pc_write_en,
  output logic             hazard_stall,
  output logic             flush_if,
  output logic [CNT_W-1:0] stall_count
);

  logic [31:0]      r_id, r_ex, r_mem, r_wb;
  logic [CNT_W-1:0] r_cnt;

  logic w_id_rs1, w_id_rs2, w_id_wr_unused;
  logic w_ex_rs1_unused, w_ex_rs2_unused, w_ex_wr;

  inst_src_decode u_dec_id (
    .i_opcode    (f_op(r_id)),
    .o_uses_rs1  (w_id_rs1),
    .o_uses_rs2  (w_id_rs2),
    .o_writes_rd (w_id_wr_unused)
  );

  inst_src_decode u_dec_ex (
    .i_opcode    (f_op(r_ex)),
    .o_uses_rs1  (w_ex_rs1_unused),
    .o_uses_rs2  (w_ex_rs2_unused),
    .o_writes_rd (w_ex_wr)
  );

  logic [4:0] w_rs1, w_rs2, w_ex_rd, w_mem_rd;
  logic       w_load_use, w_br_load, w_hazard;

  assign w_rs1    = f_rs1(r_id);
  assign w_rs2    = f_rs2(r_id);
  assign w_ex_rd  = f_rd(r_ex);
  assign w_mem_rd = f_rd(r_mem);

  // Load in EX feeding any used source of ID.
  assign w_load_use = (f_op(r_ex) == L_TYPE) && w_ex_wr && (w_ex_rd != 5'd0) &&
                      ((w_id_rs1 && (w_rs1 == w_ex_rd)) ||
                       (w_id_rs2 && (w_rs2 == w_ex_rd)));

  // Branch operands resolve in ID; a load result in MEM cannot reach them.
  assign w_br_load  = (f_op(r_id) == B_TYPE) && (f_op(r_mem) == L_TYPE) &&
                      (w_mem_rd != 5'd0) &&
                      ((w_rs1 == w_mem_rd) || (w_rs2 == w_mem_rd));

  // ext_stall dominates: the pipeline is frozen, so nothing else is "active".
  assign w_hazard     = (w_load_use || w_br_load) && !ext_stall;
  assign hazard_stall = w_hazard;
  assign pc_write_en  = !ext_stall && !w_hazard;
  assign flush_if     = branch_taken && !ext_stall && !w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id  <= BUBBLE;
      r_ex  <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
      r_cnt <= '0;
    end else if (ext_stall) begin
      // hold everything
    end else if (w_hazard) begin
      r_ex  <= BUBBLE;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_id  <= branch_taken ? BUBBLE : if_inst;
      r_ex  <= r_id;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign inst_id     = r_id;
  assign inst_ex     = r_ex;
  assign inst_mem    = r_mem;
  assign inst_wb     = r_wb;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] LW    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD   = 32'h006283B3; // add  x7,x5,x6
  localparam logic [31:0] BEQ   = 32'h00628063; // beq  x5,x6
  localparam logic [31:0] ADDI  = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD0  = 32'h006003B3; // add  x7,x0,x6

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_inst = '0;
  logic        branch_taken = 1'b0;
  logic        ext_stall = 1'b0;
  logic [31:0] inst_id, inst_ex, inst_mem, inst_wb;
  logic        pc_write_en, hazard_stall, flush_if;
  logic [15:0] stall_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .branch_taken(branch_taken),
    .ext_stall(ext_stall), .inst_id(inst_id), .inst_ex(inst_ex),
    .inst_mem(inst_mem), .inst_wb(inst_wb), .pc_write_en(pc_write_en),
    .hazard_stall(hazard_stall), .flush_if(flush_if), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_inst = '0; branch_taken = 1'b0; ext_stall = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_id",  inst_id,  32'h0);
    chk("rst_ex",  inst_ex,  32'h0);
    chk("rst_mem", inst_mem, 32'h0);
    chk("rst_wb",  inst_wb,  32'h0);
    chk("rst_cnt", {16'h0, stall_count}, 32'h0);
    chk("rst_pcwe", {31'h0, pc_write_en}, 32'h1);
    chk("rst_haz",  {31'h0, hazard_stall}, 32'h0);
    chk("rst_fl",   {31'h0, flush_if}, 32'h0);
    do_reset();

    // Load-use: one stall cycle
    if_inst = LW;  tick();
    if_inst = ADD; tick();
    if_inst = 32'h0;
    chk("lu_id",   inst_id, ADD);
    chk("lu_ex",   inst_ex, LW);
    chk("lu_haz",  {31'h0, hazard_stall}, 32'h1);
    chk("lu_pcwe", {31'h0, pc_write_en}, 32'h0);
    tick();
    chk("lu_haz2", {31'h0, hazard_stall}, 32'h0);
    chk("lu_id2",  inst_id, ADD);
    chk("lu_ex2",  inst_ex, 32'h0);
    chk("lu_mem2", inst_mem, LW);
    chk("lu_cnt",  {16'h0, stall_count}, 32'd1);
    tick();
    chk("lu_ex3",  inst_ex, ADD);
    chk("lu_wb3",  inst_wb, LW);
    chk("lu_cnt3", {16'h0, stall_count}, 32'd1);

    // Branch on load: two stall cycles
    do_reset();
    if_inst = LW;  tick();
    if_inst = BEQ; tick();
    if_inst = 32'h0;
    chk("bl_haz1", {31'h0, hazard_stall}, 32'h1);
    tick();
    chk("bl_haz2", {31'h0, hazard_stall}, 32'h1);
    chk("bl_id2",  inst_id, BEQ);
    chk("bl_mem2", inst_mem, LW);
    tick();
    chk("bl_haz3", {31'h0, hazard_stall}, 32'h0);
    chk("bl_id3",  inst_id, BEQ);
    chk("bl_cnt",  {16'h0, stall_count}, 32'd2);
    tick();
    chk("bl_ex4",  inst_ex, BEQ);

    // Reset while stalled
    do_reset();
    if_inst = LW;  tick();
    if_inst = BEQ; tick();
    tick();
    chk("rm_haz",  {31'h0, hazard_stall}, 32'h1);
    chk("rm_cnt0", {16'h0, stall_count}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_id",   inst_id, 32'h0);
    chk("rm_mem",  inst_mem, 32'h0);
    chk("rm_cnt",  {16'h0, stall_count}, 32'd0);
    chk("rm_pcwe", {31'h0, pc_write_en}, 32'h1);
    chk("rm_haz2", {31'h0, hazard_stall}, 32'h0);
    do_reset();

    // Branch after ALU writer: forwarded, no stall
    if_inst = ADDI; tick();
    if_inst = BEQ;  tick();
    if_inst = 32'h0;
    chk("ba_haz",  {31'h0, hazard_stall}, 32'h0);
    tick();
    chk("ba_haz2", {31'h0, hazard_stall}, 32'h0);
    chk("ba_ex",   inst_ex, BEQ);
    chk("ba_mem",  inst_mem, ADDI);

    // Taken branch flushes the wrong-path fetch
    do_reset();
    if_inst = BEQ; tick();
    if_inst = ADD; branch_taken = 1'b1;
    #1;
    chk("tb_flush", {31'h0, flush_if}, 32'h1);
    chk("tb_pcwe",  {31'h0, pc_write_en}, 32'h1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("tb_flush2", {31'h0, flush_if}, 32'h0);
    chk("tb_id",   inst_id, 32'h0);
    chk("tb_ex",   inst_ex, BEQ);

    // ext_stall freezes the load-use case for 3 cycles
    do_reset();
    if_inst = LW;  tick();
    if_inst = ADD; tick();
    if_inst = 32'h0; ext_stall = 1'b1;
    #1;
    chk("es_haz",  {31'h0, hazard_stall}, 32'h0);
    chk("es_pcwe", {31'h0, pc_write_en}, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("es_id",   inst_id, ADD);
    chk("es_ex",   inst_ex, LW);
    chk("es_mem",  inst_mem, 32'h0);
    chk("es_cnt",  {16'h0, stall_count}, 32'd0);
    ext_stall = 1'b0;
    #1;
    chk("es_haz2", {31'h0, hazard_stall}, 32'h1);
    tick();
    chk("es_haz3", {31'h0, hazard_stall}, 32'h0);
    chk("es_ex3",  inst_ex, 32'h0);
    chk("es_cnt3", {16'h0, stall_count}, 32'd1);

    // rd = x0 never creates a hazard
    do_reset();
    if_inst = LW0;  tick();
    if_inst = ADD0; tick();
    if_inst = 32'h0;
    chk("x0_haz",  {31'h0, hazard_stall}, 32'h0);
    chk("x0_pcwe", {31'h0, pc_write_en}, 32'h1);
    tick();
    chk("x0_ex",   inst_ex, ADD0);
    chk("x0_cnt",  {16'h0, stall_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
